// File: rtl/mat_stream_loader.sv
// mat_stream_loader: collects a row-major element stream into a SIZE_A x SIZE_B
// matrix and presents it to the downstream transpose stage until acknowledged.
// Optional macro MAT_LOADER_DOUBLE_BUF_EN adds a second bank so filling can
// continue while the other bank is being presented.
module mat_stream_loader #(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int N_BITS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [N_BITS-1:0] in_data,
    output logic                     in_ready,
    input  logic                     clear,
    output logic signed [N_BITS-1:0] mat_out [SIZE_A][SIZE_B],
    output logic                     mat_valid,
    input  logic                     mat_ack
);
    localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(SIZE_A - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(SIZE_B - 1);

    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic          in_ready_q;
    logic          accept;
    logic          last_elem;

    // in_ready_q is registered, so accept has no path from in_valid to in_ready
    assign accept    = in_valid && in_ready_q && !clear;
    assign last_elem = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign in_ready  = in_ready_q;

    // Write position: column wraps into the next row, last element wraps to origin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clear) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

`ifdef MAT_LOADER_DOUBLE_BUF_EN
    logic signed [N_BITS-1:0] mem_q [2][SIZE_A][SIZE_B];
    logic [1:0] full_q;
    logic [1:0] full_d;
    logic       wr_sel_q;
    logic       rd_sel_q;
    logic       done;
    logic       take;

    // A bank completes when its last element lands; the presented bank is
    // released on ack. When rd_sel == wr_sel both banks share one state, so a
    // completion and a release can never target the same bank in one cycle.
    assign done = accept && last_elem;
    assign take = mat_ack && full_q[rd_sel_q];

    // Next bank-full flags
    always_comb begin
        full_d = full_q;
        if (done) full_d[wr_sel_q] = 1'b1;
        if (take) full_d[rd_sel_q] = 1'b0;
    end

    // Bank bookkeeping; ready drops only when both banks hold complete matrices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else if (clear) begin
            full_q     <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            full_q     <= full_d;
            in_ready_q <= ~&full_d;
            if (done) wr_sel_q <= ~wr_sel_q;
            if (take) rd_sel_q <= ~rd_sel_q;
        end
    end

    // Element storage, no reset: contents only matter once a bank is complete
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_sel_q][row_q][col_q] <= in_data;
    end

    assign mat_valid = full_q[rd_sel_q];

    // Present the bank currently being read
    always_comb begin
        for (int r = 0; r < SIZE_A; r++) begin
            for (int c = 0; c < SIZE_B; c++) begin
                mat_out[r][c] = mem_q[rd_sel_q][r][c];
            end
        end
    end
`else
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e state_q;
    logic   mat_valid_q;
    logic signed [N_BITS-1:0] mem_q [SIZE_A][SIZE_B];

    // FILL accepts elements; HOLD presents the matrix until acked. Outputs are
    // registered alongside the state so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            mat_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else if (clear) begin
            state_q     <= FILL;
            mat_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept && last_elem) begin
                        state_q     <= HOLD;
                        mat_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                    end else begin
                        in_ready_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (mat_ack) begin
                        state_q     <= FILL;
                        mat_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    // Element storage, no reset: contents only matter in HOLD
    always_ff @(posedge clk) begin
        if (accept) mem_q[row_q][col_q] <= in_data;
    end

    assign mat_valid = mat_valid_q;

    // Single bank is presented directly
    always_comb begin
        for (int r = 0; r < SIZE_A; r++) begin
            for (int c = 0; c < SIZE_B; c++) begin
                mat_out[r][c] = mem_q[r][c];
            end
        end
    end
`endif

endmodule

// File: tb/tb_mat_stream_loader.sv
// Directed bench for mat_stream_loader at SIZE_A=2, SIZE_B=3, N_BITS=32.
// Builds for either the single-bank default or MAT_LOADER_DOUBLE_BUF_EN.
module tb_mat_stream_loader;
    localparam int SA = 2;
    localparam int SB = 3;
    localparam int NB = 32;
`ifdef MAT_LOADER_DOUBLE_BUF_EN
    localparam logic DB = 1'b1;
`else
    localparam logic DB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic signed [NB-1:0] in_data;
    logic in_ready;
    logic clear;
    logic signed [NB-1:0] mat_out [SA][SB];
    logic mat_valid;
    logic mat_ack;

    int n_vec = 0;
    int n_err = 0;
    int exp_m [SA*SB];

    always #5 clk = ~clk;

    mat_stream_loader #(.SIZE_A(SA), .SIZE_B(SB), .N_BITS(NB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .clear    (clear),
        .mat_out  (mat_out),
        .mat_valid(mat_valid),
        .mat_ack  (mat_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one element and wait (bounded) until it is taken
    task automatic push(input int d);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 40 && !ok; t++) begin
            ok = in_ready;
            step();
        end
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic chk_mat(input string tag);
        for (int r = 0; r < SA; r++)
            for (int c = 0; c < SB; c++)
                chk(tag, mat_out[r][c], exp_m[r*SB+c]);
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < SA*SB; i++) begin
            exp_m[i] = base + i;
            push(base + i);
        end
    endtask

    task automatic ack();
        mat_ack = 1'b1;
        step();
        mat_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0; mat_ack = 1'b0;
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", mat_valid, 0);
        step(); step();
        rst_n = 1'b1;
        chk("rel_ready_pre", in_ready, 0);
        step();
        chk("rel_ready", in_ready, 1);
        chk("rel_valid", mat_valid, 0);

        // 1..6 back to back
        for (int i = 0; i < 6; i++) begin
            exp_m[i] = i + 1;
            push(i + 1);
            if (i == 4) chk("valid_early", mat_valid, 0);
        end
        chk("b2b_valid", mat_valid, 1);
        chk("b2b_ready", in_ready, {31'd0, DB});
        chk_mat("b2b_mat");

`ifndef MAT_LOADER_DOUBLE_BUF_EN
        // Hold with a pending element that must not be taken
        in_valid = 1'b1; in_data = 99;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_valid", mat_valid, 1);
            chk("hold_ready", in_ready, 0);
        end
        chk_mat("hold_mat");
        in_valid = 1'b0;
        ack();
        chk("ack_valid", mat_valid, 0);
        chk("ack_ready", in_ready, 1);
`else
        // Second bank fills while the first is presented
        for (int i = 0; i < 6; i++) push(i + 7);
        chk("db_full_ready", in_ready, 0);
        chk("db_full_valid", mat_valid, 1);
        for (int i = 0; i < 6; i++) exp_m[i] = i + 1;
        chk_mat("db_mat1");
        ack();
        chk("db_ack1_valid", mat_valid, 1);
        chk("db_ack1_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) exp_m[i] = i + 7;
        chk_mat("db_mat2");
        ack();
        chk("db_ack2_valid", mat_valid, 0);

        // Completion and ack in the same cycle keep mat_valid high
        fill(31);
        for (int i = 0; i < 5; i++) push(41 + i);
        mat_ack = 1'b1;
        push(46);
        mat_ack = 1'b0;
        chk("db_swap_valid", mat_valid, 1);
        for (int i = 0; i < 6; i++) exp_m[i] = 41 + i;
        chk_mat("db_swap_mat");
        ack();
        chk("db_swap_drop", mat_valid, 0);
`endif

        // Ack while nothing is presented is ignored
        push(500); push(501);
        ack();
        chk("idle_ack_valid", mat_valid, 0);
        chk("idle_ack_ready", in_ready, 1);

        // Partial fill, clear (colliding with an offered element), then -1..-6
        for (int i = 0; i < 2; i++) push(10 * (i + 1));
        clear = 1'b1; in_valid = 1'b1; in_data = 77;
        step();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_valid", mat_valid, 0);
        chk("clr_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            exp_m[i] = -(i + 1);
            push(-(i + 1));
        end
        chk("clr_fill_valid", mat_valid, 1);
        chk_mat("clr_mat");
        ack();

        // Asynchronous reset while a matrix is presented
        fill(11);
        chk("pre_rst_valid", mat_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", mat_valid, 0);
        chk("async_rst_ready", in_ready, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_valid", mat_valid, 0);
        fill(21);
        chk("post_rst_fill", mat_valid, 1);
        chk_mat("post_rst_mat");
        ack();

        // Random in_valid over three matrices
        for (int m = 0; m < 3; m++) begin
            int k;
            int guard;
            logic v;
            logic ok;
            k = 0; guard = 0;
            while (k < 6 && guard < 300) begin
                v = 1'($urandom_range(0, 1));
                in_valid = v;
                in_data  = v ? 200 + m * 10 + k : 32'hdead;
                ok = v && in_ready;
                step();
                guard++;
                if (ok) begin
                    exp_m[k] = 200 + m * 10 + k;
                    k++;
                end
            end
            in_valid = 1'b0;
            chk("rand_cnt", k, 6);
            chk("rand_valid", mat_valid, 1);
            chk("rand_ready", in_ready, {31'd0, DB});
            chk_mat("rand_mat");
            ack();
            chk("rand_ack", mat_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
